bcd_dabble_seq: RTL
===================

# bcd_dabble_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 algorithm, one bit per clock. It replaces the purely combinational ddab2/ddab4 converters where WIDTH/DIGITS make the combinational add-3 array too deep. It sits between a binary counter or value source and the seven-segment digit drivers. It adds a valid/ready handshake, overflow saturation, and a leading-zero blanking mask that the seven-segment drivers consume directly as their blank inputs.

## Interface
- WIDTH, 14, binary input width; legal range 1..32
- DIGITS, 4, number of BCD output digits; legal range 1..10
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  bin is presented for conversion
- in_ready  output  1  converter can accept; equals (state == IDLE)
- bin  input  WIDTH  unsigned binary value, sampled on accept
- out_valid  output  1  bcd/blank_mask/ovf hold a finished result
- out_ready  input  1  consumer takes the result
- bcd  output  4*DIGITS  packed digits, digit i at bits [4i+3:4i], digit 0 = ones
- blank_mask  output  DIGITS  bit i = 1 means suppress digit i (leading zero)
- ovf  output  1  last accepted bin was ≥ 10^DIGITS

## Operation
- FSM states:
  - IDLE: in_ready = 1.
  - SHIFT: iteration counter counts WIDTH down to 1.
  - DONE: out_valid = 1.
- Accept happens when in_valid && in_ready at a rising edge:
  - Load bin into the shift register.
  - Clear the working BCD register.
  - Latch ovf_next = (bin ≥ 10^DIGITS). Compare against a localparam that is wide enough to hold 10^DIGITS without truncation.
  - Go to SHIFT.
- Each SHIFT edge performs exactly one iteration:
  - Every working digit ≥ 5 gets +3.
  - Then {working BCD, shift register} shifts left by 1; the MSB of bin enters digit 0.
  - The bit leaving the top digit is discarded.
- After the WIDTH-th iteration, go to DONE and load the output registers:
  - ovf ← ovf_next.
  - bcd ← all digits 4'h9 if ovf_next, else the working BCD.
  - blank_mask is computed from the loaded bcd. Bit i = 1 iff digits i..DIGITS-1 are all zero, for i ≥ 1. Bit 0 is always 0.
- DONE holds until out_ready = 1 at an edge, then returns to IDLE. out_valid drops on that edge.
- No new input is accepted in SHIFT or DONE. in_valid is ignored there and bin may change freely.
- bcd, blank_mask and ovf change only on entry to DONE. They stay stable through the following IDLE/SHIFT until the next DONE entry.
- Arithmetic is unsigned. Digit additions wrap within 4 bits and can never exceed 4'hC before the shift.

## Timing
- Asynchronous reset values:
  - State = IDLE, so in_ready = 1.
  - out_valid = 0, bcd = 0, ovf = 0, working registers = 0.
  - blank_mask = all ones except bit 0, e.g. 4'b1110 for DIGITS = 4.
- Latency: accept at edge E0 → out_valid high after edge E0+WIDTH, i.e. WIDTH cycles later.
- Throughput with out_ready tied high: one result every WIDTH+2 cycles.
  - Accept edge, WIDTH SHIFT edges, one DONE edge.
  - IDLE is then visible for at least one cycle before the next accept.
- in_ready is combinational from the state register only; no combinational path from in_valid.
- out_valid is registered.
- Reset asserted mid-SHIFT or in DONE:
  - Immediately forces the reset values.
  - The in-flight conversion is lost with no partial output.
  - The first accept after rst_n deasserts converts normally.
- WIDTH = 1:
  - A single SHIFT iteration.
  - bin = 1 → bcd = 1, ovf = 0 provided DIGITS ≥ 1.

## Test plan
- Reset: hold rst_n low → in_ready = 1, out_valid = 0, bcd = 16'h0000, blank_mask = 4'b1110, ovf = 0. Defaults WIDTH = 14, DIGITS = 4.
- Single conversion: bin = 2024 accepted at edge E0 → out_valid first high exactly 14 cycles later, bcd = 16'h2024, blank_mask = 4'b0000, ovf = 0.
- Boundaries and blanking:
  - bin = 0 → bcd = 16'h0000, mask 4'b1110.
  - bin = 7 → bcd = 16'h0007, mask 4'b1110.
  - bin = 305 → bcd = 16'h0305, mask 4'b1000.
  - bin = 9999 → bcd = 16'h9999, mask 4'b0000, ovf = 0.
  - Sparse sweep 0..9999 step 173 matches a /,% oracle.
- Overflow:
  - bin = 10000 → ovf = 1, bcd = 16'h9999.
  - Instance WIDTH = 8, DIGITS = 2: bin = 255 → ovf = 1, bcd = 8'h99.
  - Same instance: bin = 59 → 8'h59, ovf = 0.
  - Instance WIDTH = 6, DIGITS = 2: full sweep 0..59 matches the oracle.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with bin = 1111 → outputs stay 16'h2024, in_ready = 0, no accept. Raise out_ready → out_valid falls next edge, in_ready = 1, then 1111 converts correctly.
- Reset mid-operation: assert rst_n low after 5 SHIFT iterations of bin = 4321 → reset values immediately. After release, bin = 1234 → bcd = 16'h1234 after 14 cycles.

Source files
------------

// File: rtl/bcd_dabble_seq.sv
// rtl/bcd_dabble_seq.sv - sequential binary-to-BCD converter, shift-and-add-3, one bit per clock
// Saturates to all nines on overflow and produces a leading-zero blanking mask.
module bcd_dabble_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // 10^10 needs 34 bits, so the limit lives in a 64-bit constant
    localparam logic [63:0]       LIMIT    = f_pow10(DIGITS);
    localparam logic [DIGITS-1:0] MASK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_shift;
    logic [BW-1:0]       r_work;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf_next;
    logic [BW-1:0]       r_bcd;
    logic [DIGITS-1:0]   r_mask;
    logic                r_ovf;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_last;
    logic [BW-1:0]       w_adj;
    logic [BW-1:0]       w_next_work;
    logic [BW-1:0]       w_load_bcd;
    logic [DIGITS-1:0]   w_load_mask;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign bcd        = r_bcd;
    assign blank_mask = r_mask;
    assign ovf        = r_ovf;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_work[4*i +: 4];
            end
        end
    end

    // The bit shifted out of the top digit is dropped by the same-width shift
    assign w_next_work = (w_adj << 1) | {{(BW-1){1'b0}}, r_shift[WIDTH-1]};
    assign w_load_bcd  = r_ovf_next ? {DIGITS{4'h9}} : w_next_work;

    always_comb begin
        logic z;
        w_load_mask = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z = z && (w_load_bcd[4*i +: 4] == 4'h0);
            w_load_mask[i] = z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_ovf_next  <= 1'b0;
            r_bcd       <= '0;
            r_mask      <= MASK_RST;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift    <= bin;
                r_work     <= '0;
                r_ovf_next <= (64'(bin) >= LIMIT);
                r_cnt      <= CW'(WIDTH);
            end else if (r_state == S_SHIFT) begin
                r_shift <= r_shift << 1;
                r_work  <= w_next_work;
                r_cnt   <= r_cnt - CW'(1);
            end

            if (w_last) begin
                r_bcd       <= w_load_bcd;
                r_mask      <= w_load_mask;
                r_ovf       <= r_ovf_next;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
